neuron_pulse_sequencer: RTL and testbench

- Neuron-side responder to the unsigned matmul sequencer. It accepts sample, CDS and register-reset requests from the matmul control FSM.
- Generates the chip-facing integrator timing: reset, sample, integrate and input-drive phases, repeated num_pulses times.
- Reports completion via idle, which the matmul FSM polls as neuron_idle.
- Sits between the matmul helper and the Neurram core pad drivers.

---
 rtl/neuron_pulse_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_neuron_pulse_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_pulse_sequencer.sv
// Neuron-side pulse sequencer: integrator reset, sample, integrate and drive
// phases for the Neurram core, requested by the matmul control FSM.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   sample_trigger        level request; rising edge starts a sample op
//   cds_trigger           level request; rising edge starts a one-pulse CDS op
//   reg_reset             1-cycle pulse; starts an integrator reset op
//   num_pulses            pulse count, latched when a sample op starts
//   ext_inference_enable  host inference enable
//   turn_off_inference    temporary inference override
//   idle                  high only when no op is running
//   neuron_reset          integrator reset phase
//   sample_en             sample phase
//   integ_en              integrate phase
//   input_drive_en        input drive (integrate phase of sample ops only)
//   cds_phase             high for the whole of a CDS op
//   inference_mode        registered ext_inference_enable & ~turn_off_inference
//   overrun               sticky flag: a request was dropped
module neuron_pulse_sequencer #(
  parameter int SETUP_CYCLES  = 2,
  parameter int SAMPLE_CYCLES = 2,
  parameter int INTEG_CYCLES  = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int RESET_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_trigger,
  input  logic       cds_trigger,
  input  logic       reg_reset,
  input  logic [7:0] num_pulses,
  input  logic       ext_inference_enable,
  input  logic       turn_off_inference,
  output logic       idle,
  output logic       neuron_reset,
  output logic       sample_en,
  output logic       integ_en,
  output logic       input_drive_en,
  output logic       cds_phase,
  output logic       inference_mode,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SETUP,
    S_SAMPLE,
    S_INTEG,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LD = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] INTEG_LD  = 8'(INTEG_CYCLES - 1);
  localparam logic [7:0] GAP_LD    = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] RESET_LD  = 8'(RESET_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pcount_q, pcount_d;
  logic       cds_q, cds_d;
  logic       ovr_q, ovr_d;
  logic       samp_trig_q, cds_trig_q;

  logic       idle_q, nrst_q, samp_q, integ_q;
  logic       drive_q, cphase_q, inf_q;

  logic       samp_edge, cds_edge, any_req;

  assign samp_edge = sample_trigger & ~samp_trig_q;
  assign cds_edge  = cds_trigger & ~cds_trig_q;
  assign any_req   = reg_reset | samp_edge | cds_edge;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcount_d = pcount_q;
    cds_d    = cds_q;
    ovr_d    = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (reg_reset) begin
          state_d = S_RESET;
          cnt_d   = RESET_LD;
          cds_d   = 1'b0;
          if (samp_edge | cds_edge) ovr_d = 1'b1;
        end else if (cds_edge) begin
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
          cds_d    = 1'b1;
          pcount_d = 8'd1;
          if (samp_edge) ovr_d = 1'b1;
        end else if (samp_edge) begin
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
          cds_d    = 1'b0;
          pcount_d = num_pulses;
        end
      end
      S_DONE: begin
        if (any_req) ovr_d = 1'b1;
        state_d = S_IDLE;
        cds_d   = 1'b0;
      end
      default: begin
        if (any_req) ovr_d = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          unique case (state_q)
            S_RESET: begin
              state_d = S_IDLE;
            end
            S_SETUP: begin
              if (pcount_q == 8'd0) begin
                state_d = S_DONE;
              end else begin
                state_d = S_SAMPLE;
                cnt_d   = SAMPLE_LD;
              end
            end
            S_SAMPLE: begin
              state_d = S_INTEG;
              cnt_d   = INTEG_LD;
            end
            S_INTEG: begin
              state_d = S_GAP;
              cnt_d   = GAP_LD;
            end
            S_GAP: begin
              pcount_d = pcount_q - 8'd1;
              if (pcount_q == 8'd1) begin
                state_d = S_DONE;
              end else begin
                state_d = S_SAMPLE;
                cnt_d   = SAMPLE_LD;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      pcount_q    <= 8'd0;
      cds_q       <= 1'b0;
      ovr_q       <= 1'b0;
      samp_trig_q <= 1'b1;
      cds_trig_q  <= 1'b1;
      idle_q      <= 1'b1;
      nrst_q      <= 1'b0;
      samp_q      <= 1'b0;
      integ_q     <= 1'b0;
      drive_q     <= 1'b0;
      cphase_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pcount_q    <= pcount_d;
      cds_q       <= cds_d;
      ovr_q       <= ovr_d;
      samp_trig_q <= sample_trigger;
      cds_trig_q  <= cds_trigger;
      idle_q      <= (state_d == S_IDLE);
      nrst_q      <= (state_d == S_RESET);
      samp_q      <= (state_d == S_SAMPLE);
      integ_q     <= (state_d == S_INTEG);
      drive_q     <= (state_d == S_INTEG) & ~cds_d;
      cphase_q    <= cds_d & (state_d != S_IDLE)
                           & (state_d != S_RESET);
    end
  end

  // Inference mode follows its inputs regardless of rst.
  always_ff @(posedge clk) begin
    inf_q <= ext_inference_enable & ~turn_off_inference;
  end

  assign idle           = idle_q;
  assign neuron_reset   = nrst_q;
  assign sample_en      = samp_q;
  assign integ_en       = integ_q;
  assign input_drive_en = drive_q;
  assign cds_phase      = cphase_q;
  assign inference_mode = inf_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_neuron_pulse_sequencer.sv
// Self-checking bench for neuron_pulse_sequencer.
// Ops are scored by a queue of expected per-op phase statistics.
module tb_neuron_pulse_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_trigger = 1'b1;
  logic       cds_trigger = 1'b0;
  logic       reg_reset = 1'b0;
  logic [7:0] num_pulses = 8'd0;
  logic       ext_inference_enable = 1'b0;
  logic       turn_off_inference = 1'b0;
  logic       idle, neuron_reset, sample_en, integ_en;
  logic       input_drive_en, cds_phase, inference_mode, overrun;

  neuron_pulse_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .sample_trigger       (sample_trigger),
    .cds_trigger          (cds_trigger),
    .reg_reset            (reg_reset),
    .num_pulses           (num_pulses),
    .ext_inference_enable (ext_inference_enable),
    .turn_off_inference   (turn_off_inference),
    .idle                 (idle),
    .neuron_reset         (neuron_reset),
    .sample_en            (sample_en),
    .integ_en             (integ_en),
    .input_drive_en       (input_drive_en),
    .cds_phase            (cds_phase),
    .inference_mode       (inference_mode),
    .overrun              (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int start;
    int busy;
    int sb;
    int sc;
    int smax;
    int ib;
    int ic;
    int imax;
    int dc;
    int cc;
    int rc;
  } op_t;

  op_t sb_q[$];
  bit  mon_en = 1'b1;

  function automatic op_t exp_sample(input int n, input int st);
    op_t e;
    e.start = st;
    e.busy  = (n == 0) ? 3 : 2 + 8 * n + 1;
    e.sb    = n;
    e.sc    = 2 * n;
    e.smax  = (n == 0) ? 0 : 2;
    e.ib    = n;
    e.ic    = 4 * n;
    e.imax  = (n == 0) ? 0 : 4;
    e.dc    = 4 * n;
    e.cc    = 0;
    e.rc    = 0;
    return e;
  endfunction

  function automatic op_t exp_cds(input int st);
    op_t e;
    e.start = st;
    e.busy  = 11;
    e.sb    = 1;
    e.sc    = 2;
    e.smax  = 2;
    e.ib    = 1;
    e.ic    = 4;
    e.imax  = 4;
    e.dc    = 0;
    e.cc    = 11;
    e.rc    = 0;
    return e;
  endfunction

  function automatic op_t exp_rst(input int st);
    op_t e;
    e = '{default: 0};
    e.start = st;
    e.busy  = 4;
    e.rc    = 4;
    return e;
  endfunction

  // Monitor: measure each idle-low window and score it.
  op_t a, e;
  bit  in_op = 1'b0;
  bit  s_prev = 1'b0, i_prev = 1'b0;
  int  s_run, i_run;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      in_op = 1'b0;
    end else if (!idle) begin
      if (!in_op) begin
        in_op = 1'b1;
        a = '{default: 0};
        a.start = cyc;
        s_run = 0;
        i_run = 0;
      end
      a.busy++;
      if (sample_en) begin
        a.sc++;
        if (!s_prev) a.sb++;
        s_run++;
        if (s_run > a.smax) a.smax = s_run;
      end else s_run = 0;
      if (integ_en) begin
        a.ic++;
        if (!i_prev) a.ib++;
        i_run++;
        if (i_run > a.imax) a.imax = i_run;
      end else i_run = 0;
      a.dc += int'(input_drive_en);
      a.cc += int'(cds_phase);
      a.rc += int'(neuron_reset);
    end else begin
      chk("idle_quiet", int'({sample_en, integ_en, input_drive_en,
          neuron_reset, cds_phase}), 0);
      if (in_op) begin
        in_op = 1'b0;
        if (sb_q.size() == 0) begin
          chk("unexpected_op", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("start_cycle", a.start, e.start);
          chk("busy_len", a.busy, e.busy);
          chk("sample_bursts", a.sb, e.sb);
          chk("sample_cycles", a.sc, e.sc);
          chk("sample_burst_len", a.smax, e.smax);
          chk("integ_bursts", a.ib, e.ib);
          chk("integ_cycles", a.ic, e.ic);
          chk("integ_burst_len", a.imax, e.imax);
          chk("drive_cycles", a.dc, e.dc);
          chk("cds_cycles", a.cc, e.cc);
          chk("reset_cycles", a.rc, e.rc);
        end
      end
    end
    s_prev = sample_en;
    i_prev = integ_en;
  end

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("op_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_sample(input int n);
    @(negedge clk);
    num_pulses = 8'(n);
    sample_trigger = 1'b1;
    sb_q.push_back(exp_sample(n, cyc + 1));
    repeat (4) @(negedge clk);
    sample_trigger = 1'b0;
  endtask

  task automatic run_cds();
    @(negedge clk);
    cds_trigger = 1'b1;
    sb_q.push_back(exp_cds(cyc + 1));
    repeat (4) @(negedge clk);
    cds_trigger = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset with sample_trigger held high: must not fire.
    repeat (3) @(negedge clk);
    chk("rst_idle", int'(idle), 1);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_outs", int'({neuron_reset, sample_en, integ_en,
        input_drive_en, cds_phase}), 0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("held_trig_idle", int'(idle), 1);
    end
    chk("held_trig_overrun", int'(overrun), 0);
    sample_trigger = 1'b0;
    @(negedge clk);

    // Inference mode follows its inputs one cycle later.
    ext_inference_enable = 1'b1;
    @(negedge clk);
    chk("inf_on", int'(inference_mode), 1);
    turn_off_inference = 1'b1;
    @(negedge clk);
    chk("inf_override", int'(inference_mode), 0);
    turn_off_inference = 1'b0;
    ext_inference_enable = 1'b0;
    @(negedge clk);
    chk("inf_off", int'(inference_mode), 0);

    run_sample(3);
    wait_done();
    chk("ovr_after_sample", int'(overrun), 0);

    run_cds();
    wait_done();

    run_sample(0);
    wait_done();

    @(negedge clk);
    reg_reset = 1'b1;
    sb_q.push_back(exp_rst(cyc + 1));
    @(negedge clk);
    reg_reset = 1'b0;
    wait_done();
    chk("ovr_after_regrst", int'(overrun), 0);

    // reg_reset wins over a simultaneous CDS edge.
    @(negedge clk);
    reg_reset = 1'b1;
    cds_trigger = 1'b1;
    sb_q.push_back(exp_rst(cyc + 1));
    @(negedge clk);
    reg_reset = 1'b0;
    repeat (3) @(negedge clk);
    cds_trigger = 1'b0;
    wait_done();
    chk("ovr_collision", int'(overrun), 1);

    pulse_rst();
    @(negedge clk);
    chk("ovr_cleared", int'(overrun), 0);

    // Second sample edge during pulse 2 is dropped.
    run_sample(3);
    repeat (8) @(negedge clk);
    sample_trigger = 1'b1;
    repeat (2) @(negedge clk);
    sample_trigger = 1'b0;
    wait_done();
    chk("ovr_mid_op", int'(overrun), 1);

    // Abort mid-integrate with rst.
    mon_en = 1'b0;
    @(negedge clk);
    num_pulses = 8'd2;
    sample_trigger = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (integ_en) begin
          seen = 1'b1;
          break;
        end
      end
      chk("reach_integ", int'(seen), 1);
    end
    sample_trigger = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle", int'(idle), 1);
    chk("abort_integ", int'(integ_en), 0);
    chk("abort_drive", int'(input_drive_en), 0);
    chk("abort_overrun", int'(overrun), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Maximum pulse count.
    run_sample(255);
    wait_done();
    chk("ovr_final", int'(overrun), 0);
    chk("queue_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
